// File: rtl/multdiv_issue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multdiv_issue_ctrl_if                                                      |
// | Issue, multdiv-unit and writeback signals of the multdiv issue controller. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface multdiv_issue_ctrl_if;
    logic        issue_valid;
    logic        issue_mult;
    logic        issue_div;
    logic [31:0] issue_opA;
    logic [31:0] issue_opB;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        stall;
    logic        issue_err;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_exception;
    logic        wb_timeout;

    // Controller side
    modport slave (
        input  issue_valid, issue_mult, issue_div, issue_opA, issue_opB, issue_rd,
        input  flush, md_result, md_exception, md_resultRDY, wb_ready,
        output stall, issue_err, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        output wb_valid, wb_data, wb_rd, wb_exception, wb_timeout
    );

    // Pipeline / multdiv / writeback side
    modport master (
        output issue_valid, issue_mult, issue_div, issue_opA, issue_opB, issue_rd,
        output flush, md_result, md_exception, md_resultRDY, wb_ready,
        input  stall, issue_err, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        input  wb_valid, wb_data, wb_rd, wb_exception, wb_timeout
    );
endinterface
`default_nettype wire

// File: rtl/multdiv_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multdiv_issue_ctrl                                                         |
// | Sequences one MULT/DIV through the shared multdiv unit and hands the       |
// | result to writeback; flush and watchdog aware.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multdiv_issue_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  wire logic            clock,
    input  wire logic            reset,
    multdiv_issue_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_rd;
    logic             w_expired;
    logic             w_handshake;

    assign w_expired   = (r_cnt == c_CNT_LAST);
    assign w_handshake = bus.wb_ready & ~bus.flush;

    // Stall releases in the handshake cycle itself; in DRAIN it only holds back a new issue.
    assign bus.stall = (r_state == S_START) || (r_state == S_BUSY)
                    || ((r_state == S_DONE) && !w_handshake)
                    || ((r_state == S_DRAIN) && bus.issue_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_rd             <= '0;
            bus.issue_err    <= 1'b0;
            bus.md_operandA  <= '0;
            bus.md_operandB  <= '0;
            bus.md_ctrl_MULT <= 1'b0;
            bus.md_ctrl_DIV  <= 1'b0;
            bus.wb_valid     <= 1'b0;
            bus.wb_data      <= '0;
            bus.wb_rd        <= '0;
            bus.wb_exception <= 1'b0;
            bus.wb_timeout   <= 1'b0;
        end else begin
            bus.issue_err    <= 1'b0;
            bus.md_ctrl_MULT <= 1'b0;
            bus.md_ctrl_DIV  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.issue_valid) begin
                        if (bus.issue_mult && bus.issue_div) begin
                            bus.issue_err <= 1'b1;
                        end else if ((bus.issue_mult ^ bus.issue_div) && !bus.flush) begin
                            bus.md_operandA  <= bus.issue_opA;
                            bus.md_operandB  <= bus.issue_opB;
                            r_rd             <= bus.issue_rd;
                            bus.md_ctrl_MULT <= bus.issue_mult;
                            bus.md_ctrl_DIV  <= bus.issue_div;
                            r_state          <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= bus.flush ? S_DRAIN : S_BUSY;
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.flush) begin
                        // The unit cannot be aborted; wait it out unless it finishes now.
                        r_state <= (bus.md_resultRDY || w_expired) ? S_IDLE : S_DRAIN;
                    end else if (bus.md_resultRDY) begin
                        bus.wb_data      <= bus.md_result;
                        bus.wb_exception <= bus.md_exception;
                        bus.wb_timeout   <= 1'b0;
                        bus.wb_rd        <= r_rd;
                        bus.wb_valid     <= 1'b1;
                        r_state          <= S_DONE;
                    end else if (w_expired) begin
                        bus.wb_data      <= '0;
                        bus.wb_exception <= 1'b1;
                        bus.wb_timeout   <= 1'b1;
                        bus.wb_rd        <= r_rd;
                        bus.wb_valid     <= 1'b1;
                        r_state          <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.flush || bus.wb_ready) begin
                        bus.wb_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.md_resultRDY || w_expired) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multdiv_issue_ctrl                                                      |
// | Directed self-checking bench for multdiv_issue_ctrl.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multdiv_issue_ctrl;

    localparam int c_TIMEOUT = 64;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    multdiv_issue_ctrl_if bus();

    multdiv_issue_ctrl #(.TIMEOUT(c_TIMEOUT), .CNT_W(7)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.issue_valid  = 1'b0;
        bus.issue_mult   = 1'b0;
        bus.issue_div    = 1'b0;
        bus.issue_opA    = '0;
        bus.issue_opB    = '0;
        bus.issue_rd     = '0;
        bus.flush        = 1'b0;
        bus.md_result    = '0;
        bus.md_exception = 1'b0;
        bus.md_resultRDY = 1'b0;
        bus.wb_ready     = 1'b0;
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        bus.issue_valid = 1'b1;
        bus.issue_mult  = m;
        bus.issue_div   = d;
        bus.issue_opA   = a;
        bus.issue_opB   = b;
        bus.issue_rd    = rd;
        tick();
        bus.issue_valid = 1'b0;
        bus.issue_mult  = 1'b0;
        bus.issue_div   = 1'b0;
    endtask

    // One full op: lat extra BUSY cycles before rdy, hold cycles of wb_ready low in DONE.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] res, input logic exc, input int lat, input int hold);
        issue(m, d, a, b, rd);
        check_eq({tag, "_start_mult"}, 32'(bus.md_ctrl_MULT), 32'(m));
        check_eq({tag, "_start_div"},  32'(bus.md_ctrl_DIV),  32'(d));
        check_eq({tag, "_opA"}, bus.md_operandA, a);
        check_eq({tag, "_opB"}, bus.md_operandB, b);
        check_eq({tag, "_start_stall"}, 32'(bus.stall), 32'd1);
        tick();
        check_eq({tag, "_busy_ctrl"}, {30'd0, bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 32'd0);
        repeat (lat) tick();
        check_eq({tag, "_busy_valid"}, 32'(bus.wb_valid), 32'd0);
        bus.md_resultRDY = 1'b1;
        bus.md_result    = res;
        bus.md_exception = exc;
        tick();
        bus.md_resultRDY = 1'b0;
        bus.md_result    = 32'hA5A5A5A5;
        bus.md_exception = ~exc;
        check_eq({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
        check_eq({tag, "_wb_data"}, bus.wb_data, res);
        check_eq({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'(rd));
        check_eq({tag, "_wb_exc"}, 32'(bus.wb_exception), 32'(exc));
        check_eq({tag, "_wb_timeout"}, 32'(bus.wb_timeout), 32'd0);
        check_eq({tag, "_done_stall"}, 32'(bus.stall), 32'd1);
        if (hold > 0) begin
            bus.issue_valid = 1'b1;
            bus.issue_mult  = 1'b1;
            bus.issue_opA   = 32'h00001234;
            for (int i = 0; i < hold; i++) begin
                tick();
                check_eq({tag, "_hold_valid"}, 32'(bus.wb_valid), 32'd1);
                check_eq({tag, "_hold_data"}, bus.wb_data, res);
                check_eq({tag, "_hold_stall"}, 32'(bus.stall), 32'd1);
                check_eq({tag, "_hold_ctrl"}, 32'(bus.md_ctrl_MULT), 32'd0);
                check_eq({tag, "_hold_opA"}, bus.md_operandA, a);
            end
            bus.issue_valid = 1'b0;
            bus.issue_mult  = 1'b0;
        end
        bus.wb_ready = 1'b1;
        #1;
        check_eq({tag, "_hs_stall"}, 32'(bus.stall), 32'd0);
        tick();
        bus.wb_ready = 1'b0;
        check_eq({tag, "_idle_valid"}, 32'(bus.wb_valid), 32'd0);
        check_eq({tag, "_idle_stall"}, 32'(bus.stall), 32'd0);
    endtask

    initial begin
        int n;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_stall", 32'(bus.stall), 32'd0);
        check_eq("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check_eq("rst_ctrl", {30'd0, bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 32'd0);
        check_eq("rst_opA", bus.md_operandA, 32'd0);
        check_eq("rst_wb_data", bus.wb_data, 32'd0);

        // MULT 7 x -3
        run_op("mul", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 1'b0, 2, 0);
        // DIV overflow reported by the unit
        run_op("ovf", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h80000000, 1'b1, 5, 0);
        // Divide by zero, then 100/7 with a held-off second issue during DONE
        run_op("dz", 1'b0, 1'b1, 32'd100, 32'd0, 5'd3, 32'd0, 1'b1, 3, 0);
        run_op("div", 1'b0, 1'b1, 32'd100, 32'd7, 5'd4, 32'd14, 1'b0, 1, 10);

        // Flush three cycles after START, then drain
        issue(1'b1, 1'b0, 32'd3, 32'd4, 5'd1);
        tick();
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_eq("fl_drain_valid", 32'(bus.wb_valid), 32'd0);
        check_eq("fl_drain_stall", 32'(bus.stall), 32'd0);
        bus.issue_valid = 1'b1;
        bus.issue_div   = 1'b1;
        #1;
        check_eq("fl_drain_issue_stall", 32'(bus.stall), 32'd1);
        tick();
        tick();
        check_eq("fl_drain_ctrl", {30'd0, bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 32'd0);
        check_eq("fl_drain_opA", bus.md_operandA, 32'd3);
        bus.issue_valid  = 1'b0;
        bus.issue_div    = 1'b0;
        bus.md_resultRDY = 1'b1;
        bus.md_result    = 32'd12;
        tick();
        bus.md_resultRDY = 1'b0;
        tick();
        check_eq("fl_idle_valid", 32'(bus.wb_valid), 32'd0);
        check_eq("fl_idle_ctrl", {30'd0, bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 32'd0);
        run_op("after_fl", 1'b1, 1'b0, 32'd6, 32'd7, 5'd2, 32'd42, 1'b0, 0, 0);

        // Watchdog: unit never answers
        issue(1'b0, 1'b1, 32'd1, 32'd2, 5'd7);
        check_eq("to_start_div", 32'(bus.md_ctrl_DIV), 32'd1);
        n = 0;
        while (!bus.wb_valid && n < 200) begin
            tick();
            n++;
        end
        check_eq("to_cycles", 32'(n), 32'(c_TIMEOUT + 1));
        check_eq("to_wb_data", bus.wb_data, 32'd0);
        check_eq("to_wb_exc", 32'(bus.wb_exception), 32'd1);
        check_eq("to_wb_timeout", 32'(bus.wb_timeout), 32'd1);
        check_eq("to_wb_rd", 32'(bus.wb_rd), 32'd7);
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        check_eq("to_idle_valid", 32'(bus.wb_valid), 32'd0);

        // Both op bits set, then neither
        bus.issue_valid = 1'b1;
        bus.issue_mult  = 1'b1;
        bus.issue_div   = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        bus.issue_mult  = 1'b0;
        bus.issue_div   = 1'b0;
        check_eq("err_pulse", 32'(bus.issue_err), 32'd1);
        check_eq("err_ctrl", {30'd0, bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 32'd0);
        check_eq("err_stall", 32'(bus.stall), 32'd0);
        tick();
        check_eq("err_clear", 32'(bus.issue_err), 32'd0);
        bus.issue_valid = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        check_eq("none_ignored", {29'd0, bus.stall, bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 32'd0);

        // Reset while BUSY, then a stray rdy in IDLE
        issue(1'b1, 1'b0, 32'hCAFE0001, 32'd5, 5'd8);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rmid_stall", 32'(bus.stall), 32'd0);
        check_eq("rmid_opA", bus.md_operandA, 32'd0);
        check_eq("rmid_opB", bus.md_operandB, 32'd0);
        check_eq("rmid_valid", 32'(bus.wb_valid), 32'd0);
        bus.md_resultRDY = 1'b1;
        bus.md_result    = 32'd99;
        tick();
        bus.md_resultRDY = 1'b0;
        check_eq("idle_rdy_ignored", 32'(bus.wb_valid), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
